uart_cmd_master: RTL and testbench
==================================

# uart_cmd_master

Byte-command bridge that turns a UART receive byte stream into AXI-lite initiator transactions and serializes the results back onto the UART transmit path. It is the initiator counterpart to the UART peripheral's AXI-lite responder: a host on the serial line can read and write any 32-bit AXI-lite register. It sits between the RX buffer read port and TX buffer write port on one side and an AXI-lite master port on the other.

## Interface
- TIMEOUT, 100000: inter-byte timeout, in clk cycles, while a command is partially received.
- clk  input  1  system clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- i_rvalid  input  1  command byte valid.
- o_rready  output  1  command byte accepted when i_rvalid & o_rready.
- i_rdata  input  8  command byte.
- o_wvalid  output  1  response byte valid.
- i_wready  input  1  response byte accepted when o_wvalid & i_wready.
- o_wdata  output  8  response byte.
- o_busy  output  1  high in any state other than IDLE.
- o_timeout  output  1  one-cycle pulse when a partial command is aborted.
- axi  modport  axi_lite_if.M  AXI-lite initiator, 32-bit address, 32-bit data.

## Operation
- Command format; multi-byte fields are MSB first:
  - Write: 0x57 'W', then 4 address bytes, then 4 data bytes.
  - Read: 0x52 'R', then 4 address bytes.
- Any other first byte: send reply 0x3F '?', then return to IDLE.
- States and transitions:
  - IDLE -> ADDR on W or R.
  - ADDR counts 4 bytes, then goes to DATA for W or AR for R.
  - DATA counts 4 bytes, then goes to AW.
  - AW (write address/data issue) -> B.
  - AR -> R.
  - B and R -> RESP.
  - RESP -> IDLE.
- Write issue (AW): awvalid and wvalid rise together. Each deasserts independently on its own handshake. Leave AW when both have completed.
- Write signal values: wstrb = 4'hF, awprot = 3'b000.
- B: bready = 1. Capture bresp on the bvalid handshake.
- AR: arvalid held until arready; arprot = 3'b000.
- R: rready = 1. Capture rresp and rdata on the rvalid handshake.
- Status byte: 0x06 if resp = OKAY, else 0x15.
- Reply contents: a write replies with the status byte only. A read replies with the status byte followed by 4 rdata bytes, MSB first, sent regardless of status.
- o_rready = 1 only in IDLE, ADDR and DATA. Bytes arriving in other states are backpressured, never dropped.
- Timeout counter:
  - Runs in ADDR and DATA and clears on every accepted byte.
  - When it reaches TIMEOUT-1: go to IDLE, pulse o_timeout, send no reply, issue no AXI transaction.
- There is no AXI timeout. A hung slave stalls the block until rst.

## Timing
- Reset values: o_rready = 0 while rst is high, 1 on the first cycle after release (IDLE). All other outputs are 0, including o_wvalid, o_wdata, o_busy, o_timeout and all axi valid/ready outputs.
- Input capture: a byte accepted in cycle n is registered at the cycle-n edge. The state advances in the same edge.
- Write: last data byte accepted in cycle n -> awvalid/wvalid high in n+1. If the slave is always ready, both handshakes complete in n+1.
- Read: last address byte accepted in cycle n -> arvalid high in n+1.
- Response handshake in cycle m -> o_wvalid high in m+1 with the status byte.
- While o_wvalid is high and i_wready is low, o_wdata must remain stable.
- Each reply byte follows the previous handshake with no gap cycle.
- Final reply-byte handshake in cycle k -> IDLE and o_rready = 1 in k+1.
- Unknown command accepted in cycle n -> '?' presented in n+1.
- AW and W handshakes may occur in the same cycle or in either order.
- bvalid may arrive in the cycle both AW/W handshakes complete. It is not consumed until the B state (next cycle).
- rst mid-transaction returns immediately to IDLE. Captured fields are discarded and axi valids drop asynchronously.

## Structure
- Shared uart_pkg holds:
  - Command constants: CMD_WR = 8'h57, CMD_RD = 8'h52.
  - Reply constants: RSP_ACK = 8'h06, RSP_NAK = 8'h15, RSP_UNK = 8'h3F.
  - The state enum type.
  - AXI resp encoding (OKAY = 2'b00).
- Internals: single module with a 32-bit address register, a 32-bit data register (reused for write data and read data), a 2-bit byte counter and a timeout counter sized $clog2(TIMEOUT).
- No sub-module; the reply serializer stays inline.

## Test plan
- W 0x00000010 0xDEADBEEF with OKAY slave -> exactly one AXI write, awaddr = 0x10, wdata = 0xDEADBEEF, wstrb = 0xF; reply 0x06.
- R 0x00000004; slave returns 0x12345678 OKAY -> araddr = 0x4; reply 0x06 0x12 0x34 0x56 0x78.
- R to a SLVERR slave returning 0xFFFFFFFF -> reply 0x15 0xFF 0xFF 0xFF 0xFF.
- Byte 0x41 -> reply 0x3F; a following valid W command completes normally.
- W with 3 address bytes, then TIMEOUT idle cycles -> o_timeout pulses once, no AXI activity, no reply; next command works.
- i_wready held low 10 cycles during a read reply, awready delayed 3 cycles after wready, rst asserted mid-B -> o_wdata stable while stalled, AW and W each handshake once, outputs return to reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command bridge: command/reply bytes,
// FSM state encoding and AXI-lite response codes.
package uart_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] RSP_UNK = 8'h3F;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_ADDR = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_AW   = 3'd3;
  localparam state_t ST_B    = 3'd4;
  localparam state_t ST_AR   = 3'd5;
  localparam state_t ST_R    = 3'd6;
  localparam state_t ST_RESP = 3'd7;

  function automatic logic [7:0] status_byte(input logic [1:0] resp);
    return (resp == AXI_RESP_OKAY) ? RSP_ACK : RSP_NAK;
  endfunction

endpackage

// File: rtl/uart_cmd_master.sv
// Turns 'W'/'R' byte commands from the UART RX stream into AXI-lite transactions
// and serializes the status (and read data) back onto the UART TX stream.
module uart_cmd_master
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  // UART RX buffer read port
  input  logic        i_rvalid,
  output logic        o_rready,
  input  logic [7:0]  i_rdata,
  // UART TX buffer write port
  output logic        o_wvalid,
  input  logic        i_wready,
  output logic [7:0]  o_wdata,
  output logic        o_busy,
  output logic        o_timeout,
  // AXI-lite initiator
  output logic        o_axi_awvalid,
  input  logic        i_axi_awready,
  output logic [31:0] o_axi_awaddr,
  output logic [2:0]  o_axi_awprot,
  output logic        o_axi_wvalid,
  input  logic        i_axi_wready,
  output logic [31:0] o_axi_wdata,
  output logic [3:0]  o_axi_wstrb,
  input  logic        i_axi_bvalid,
  output logic        o_axi_bready,
  input  logic [1:0]  i_axi_bresp,
  output logic        o_axi_arvalid,
  input  logic        i_axi_arready,
  output logic [31:0] o_axi_araddr,
  output logic [2:0]  o_axi_arprot,
  input  logic        i_axi_rvalid,
  output logic        o_axi_rready,
  input  logic [31:0] i_axi_rdata,
  input  logic [1:0]  i_axi_rresp
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          is_rd_q, is_rd_d;
  logic          more_q, more_d;
  logic [7:0]    tx_q, tx_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          arvalid_q, arvalid_d;
  logic          timeout_q, timeout_d;

  logic rx_fire;
  logic tx_fire;

  // Ready is forced low while reset is held, even though the state already reads IDLE.
  assign o_rready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_ADDR) | (state_q == ST_DATA));
  assign o_wvalid = (state_q == ST_RESP);
  assign o_wdata  = tx_q;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_timeout = timeout_q;

  assign rx_fire = i_rvalid & o_rready;
  assign tx_fire = o_wvalid & i_wready;

  assign o_axi_awvalid = awvalid_q;
  assign o_axi_awaddr  = addr_q;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_wdata   = data_q;
  assign o_axi_wstrb   = 4'hF;
  assign o_axi_bready  = (state_q == ST_B);
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_araddr  = addr_q;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_rready  = (state_q == ST_R);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    is_rd_d   = is_rd_q;
    more_d    = more_q;
    tx_d      = tx_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          cnt_d = 2'd0;
          if (i_rdata == CMD_WR) begin
            is_rd_d = 1'b0;
            state_d = ST_ADDR;
          end else if (i_rdata == CMD_RD) begin
            is_rd_d = 1'b1;
            state_d = ST_ADDR;
          end else begin
            tx_d    = RSP_UNK;
            more_d  = 1'b0;
            state_d = ST_RESP;
          end
        end
      end

      ST_ADDR: begin
        if (rx_fire) begin
          addr_d = {addr_q[23:0], i_rdata};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_rd_q) begin
              arvalid_d = 1'b1;
              state_d   = ST_AR;
            end else begin
              state_d = ST_DATA;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_DATA: begin
        if (rx_fire) begin
          data_d = {data_q[23:0], i_rdata};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_AW;
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_AW: begin
        awvalid_d = awvalid_q & ~i_axi_awready;
        wvalid_d  = wvalid_q & ~i_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = ST_B;
        end
      end

      ST_B: begin
        if (i_axi_bvalid) begin
          tx_d    = status_byte(i_axi_bresp);
          more_d  = 1'b0;
          state_d = ST_RESP;
        end
      end

      ST_AR: begin
        if (i_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_R;
        end
      end

      ST_R: begin
        if (i_axi_rvalid) begin
          data_d  = i_axi_rdata;
          tx_d    = status_byte(i_axi_rresp);
          more_d  = 1'b1;
          cnt_d   = 2'd0;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // more_q flags read-data bytes still queued behind the byte on o_wdata.
        if (tx_fire) begin
          if (more_q) begin
            tx_d   = data_q[31:24];
            data_d = {data_q[23:0], 8'h00};
            cnt_d  = cnt_q + 2'd1;
            more_d = (cnt_q != 2'd3);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      is_rd_q   <= 1'b0;
      more_q    <= 1'b0;
      tx_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      is_rd_q   <= is_rd_d;
      more_q    <= more_d;
      tx_q      <= tx_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master: drives byte commands, models a simple
// AXI-lite slave with tunable latency and checks replies and bus traffic.
module tb_uart_cmd_master;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rvalid = 1'b0;
  logic        o_rready;
  logic [7:0]  i_rdata = 8'h00;
  logic        o_wvalid;
  logic        i_wready = 1'b1;
  logic [7:0]  o_wdata;
  logic        o_busy;
  logic        o_timeout;
  logic        o_axi_awvalid;
  logic        i_axi_awready = 1'b0;
  logic [31:0] o_axi_awaddr;
  logic [2:0]  o_axi_awprot;
  logic        o_axi_wvalid;
  logic        i_axi_wready = 1'b0;
  logic [31:0] o_axi_wdata;
  logic [3:0]  o_axi_wstrb;
  logic        i_axi_bvalid = 1'b0;
  logic        o_axi_bready;
  logic [1:0]  i_axi_bresp = 2'b00;
  logic        o_axi_arvalid;
  logic        i_axi_arready = 1'b0;
  logic [31:0] o_axi_araddr;
  logic [2:0]  o_axi_arprot;
  logic        i_axi_rvalid = 1'b0;
  logic        o_axi_rready;
  logic [31:0] i_axi_rdata = 32'h0;
  logic [1:0]  i_axi_rresp = 2'b00;

  uart_cmd_master #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rvalid     (i_rvalid),
    .o_rready     (o_rready),
    .i_rdata      (i_rdata),
    .o_wvalid     (o_wvalid),
    .i_wready     (i_wready),
    .o_wdata      (o_wdata),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout),
    .o_axi_awvalid(o_axi_awvalid),
    .i_axi_awready(i_axi_awready),
    .o_axi_awaddr (o_axi_awaddr),
    .o_axi_awprot (o_axi_awprot),
    .o_axi_wvalid (o_axi_wvalid),
    .i_axi_wready (i_axi_wready),
    .o_axi_wdata  (o_axi_wdata),
    .o_axi_wstrb  (o_axi_wstrb),
    .i_axi_bvalid (i_axi_bvalid),
    .o_axi_bready (o_axi_bready),
    .i_axi_bresp  (i_axi_bresp),
    .o_axi_arvalid(o_axi_arvalid),
    .i_axi_arready(i_axi_arready),
    .o_axi_araddr (o_axi_araddr),
    .o_axi_arprot (o_axi_arprot),
    .i_axi_rvalid (i_axi_rvalid),
    .o_axi_rready (o_axi_rready),
    .i_axi_rdata  (i_axi_rdata),
    .i_axi_rresp  (i_axi_rresp)
  );

  always #5 clk = ~clk;

  // Slave configuration, set by the stimulus block.
  int          aw_delay = 0;
  logic        b_en = 1'b1;
  logic [1:0]  b_resp = 2'b00;
  logic [1:0]  r_resp = 2'b00;
  logic [31:0] r_data = 32'h0;

  int checks = 0;
  int failures = 0;

  // Bus observation, updated on the active edge.
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, tmo_pulses = 0;
  logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
  logic [3:0]  cap_wstrb = 0;
  logic [2:0]  cap_awprot = 3'b111, cap_arprot = 3'b111;
  logic [7:0]  reply_q[$];
  logic        aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  int          aw_wait = 0;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  assign aw_fire = o_axi_awvalid && i_axi_awready;
  assign w_fire  = o_axi_wvalid && i_axi_wready;
  assign b_fire  = i_axi_bvalid && o_axi_bready;
  assign ar_fire = o_axi_arvalid && i_axi_arready;
  assign r_fire  = i_axi_rvalid && o_axi_rready;

  always @(posedge clk) begin
    if (aw_fire) begin
      aw_hs <= aw_hs + 1; cap_awaddr <= o_axi_awaddr; cap_awprot <= o_axi_awprot;
    end
    if (w_fire) begin
      w_hs <= w_hs + 1; cap_wdata <= o_axi_wdata; cap_wstrb <= o_axi_wstrb;
    end
    if (ar_fire) begin
      ar_hs <= ar_hs + 1; cap_araddr <= o_axi_araddr; cap_arprot <= o_axi_arprot;
    end
    if (o_wvalid && i_wready) reply_q.push_back(o_wdata);
    if (o_timeout) tmo_pulses <= tmo_pulses + 1;
    if (rst) begin
      aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
    end else begin
      if ((aw_got || aw_fire) && (w_got || w_fire)) begin
        b_pend <= 1; aw_got <= 0; w_got <= 0;
      end else begin
        aw_got <= aw_got || aw_fire; w_got <= w_got || w_fire;
      end
      if (b_fire) b_pend <= 0;
      if (ar_fire) r_pend <= 1;
      if (r_fire) r_pend <= 0;
    end
  end

  // Slave drives its outputs on the falling edge.
  always @(negedge clk) begin
    if (o_axi_awvalid) begin
      i_axi_awready = (aw_wait >= aw_delay);
      aw_wait = aw_wait + 1;
    end else begin
      i_axi_awready = 1'b0;
      aw_wait = 0;
    end
    i_axi_wready  = o_axi_wvalid;
    i_axi_arready = o_axi_arvalid;
    i_axi_bvalid  = b_pend && b_en;
    i_axi_bresp   = b_resp;
    i_axi_rvalid  = r_pend;
    i_axi_rdata   = r_data;
    i_axi_rresp   = r_resp;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    i_rvalid = 1'b1;
    i_rdata  = b;
    while (!o_rready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept", o_rready, 1);
    @(negedge clk);
    i_rvalid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[31:24]);
      v = v << 8;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, o_busy, 0);
  endtask

  task automatic check_read_reply(input string tag, input int base, input logic [7:0] st,
                                  input logic [31:0] d);
    logic [39:0] exp;
    exp = {st, d};
    check({tag, "_len"}, reply_q.size(), base + 5);
    for (int i = 0; i < 5; i++) begin
      if (reply_q.size() > base + i) check({tag, "_byte"}, reply_q[base + i], exp[39 - 8*i -: 8]);
    end
  endtask

  int base, aw0, w0, ar0, t0;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rready", o_rready, 0);
    check("rst_wvalid", o_wvalid, 0);
    check("rst_wdata", o_wdata, 0);
    check("rst_busy", o_busy, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_valids", {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_axi_bready, o_axi_rready}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rready", o_rready, 1);

    // Write 0x10 <- 0xDEADBEEF, cycle-exact
    base = reply_q.size(); aw0 = aw_hs; w0 = w_hs;
    send_byte(8'h57); send_word(32'h0000_0010); send_word(32'hDEAD_BEEF);
    check("wr_aw_issue", {o_axi_awvalid, o_axi_wvalid}, 2'b11);
    @(negedge clk);
    check("wr_in_b", {o_axi_bready, o_wvalid, o_axi_awvalid, o_axi_wvalid}, 4'b1000);
    @(negedge clk);
    check("wr_status_valid", o_wvalid, 1);
    check("wr_status_byte", o_wdata, 8'h06);
    @(negedge clk);
    check("wr_back_idle", {o_busy, o_rready}, 2'b01);
    check("wr_aw_count", aw_hs - aw0, 1);
    check("wr_w_count", w_hs - w0, 1);
    check("wr_awaddr", cap_awaddr, 32'h10);
    check("wr_awprot", cap_awprot, 0);
    check("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("wr_wstrb", cap_wstrb, 4'hF);
    check("wr_reply_len", reply_q.size(), base + 1);
    if (reply_q.size() > base) check("wr_reply", reply_q[base], 8'h06);

    // Read 0x4 -> 0x12345678 OKAY
    r_data = 32'h1234_5678; r_resp = 2'b00;
    base = reply_q.size(); ar0 = ar_hs;
    send_byte(8'h52); send_word(32'h0000_0004);
    check("rd_ar_issue", o_axi_arvalid, 1);
    wait_idle("rd_ok_done");
    check("rd_ar_count", ar_hs - ar0, 1);
    check("rd_araddr", cap_araddr, 32'h4);
    check("rd_arprot", cap_arprot, 0);
    check_read_reply("rd_ok", base, 8'h06, 32'h1234_5678);

    // Read from SLVERR slave
    r_data = 32'hFFFF_FFFF; r_resp = 2'b10;
    base = reply_q.size();
    send_byte(8'h52); send_word(32'h0000_0008);
    wait_idle("rd_err_done");
    check_read_reply("rd_err", base, 8'h15, 32'hFFFF_FFFF);
    r_resp = 2'b00;

    // Unknown command, then a normal write
    base = reply_q.size();
    send_byte(8'h41);
    check("unk_valid", o_wvalid, 1);
    check("unk_byte", o_wdata, 8'h3F);
    wait_idle("unk_done");
    check("unk_reply_len", reply_q.size(), base + 1);
    base = reply_q.size(); aw0 = aw_hs;
    send_byte(8'h57); send_word(32'h0000_0020); send_word(32'h0BAD_F00D);
    wait_idle("wr2_done");
    check("wr2_aw_count", aw_hs - aw0, 1);
    check("wr2_awaddr", cap_awaddr, 32'h20);
    check("wr2_wdata", cap_wdata, 32'h0BAD_F00D);
    check("wr2_reply_len", reply_q.size(), base + 1);
    if (reply_q.size() > base) check("wr2_reply", reply_q[base], 8'h06);

    // Partial command times out
    base = reply_q.size(); aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; t0 = tmo_pulses;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_not_yet", {o_busy, o_timeout}, 2'b10);
    @(negedge clk);
    check("tmo_pulse", {o_busy, o_timeout}, 2'b01);
    @(negedge clk);
    check("tmo_pulse_end", o_timeout, 0);
    check("tmo_pulse_count", tmo_pulses - t0, 1);
    check("tmo_no_axi", (aw_hs - aw0) + (w_hs - w0) + (ar_hs - ar0), 0);
    check("tmo_no_reply", reply_q.size(), base);
    r_data = 32'hA5C3_0F96;
    send_byte(8'h52); send_word(32'h0000_000C);
    wait_idle("tmo_next_done");
    check("tmo_next_araddr", cap_araddr, 32'hC);
    check_read_reply("tmo_next", base, 8'h06, 32'hA5C3_0F96);

    // Read reply with TX stalled for 10 cycles
    r_data = 32'hCAFE_F00D;
    i_wready = 1'b0;
    base = reply_q.size();
    send_byte(8'h52); send_word(32'h0000_0030);
    for (int n = 0; n < 20 && !o_wvalid; n++) @(negedge clk);
    check("stall_wvalid", o_wvalid, 1);
    for (int i = 0; i < 10; i++) begin
      check("stall_wdata", o_wdata, 8'h06);
      @(negedge clk);
    end
    i_wready = 1'b1;
    wait_idle("stall_done");
    check_read_reply("stall", base, 8'h06, 32'hCAFE_F00D);

    // Write with awready 3 cycles behind wready, then reset while in B
    aw_delay = 3; b_en = 1'b0;
    aw0 = aw_hs; w0 = w_hs;
    send_byte(8'h57); send_word(32'h0000_0040); send_word(32'h1122_3344);
    check("slow_aw_issue", {o_axi_awvalid, o_axi_wvalid}, 2'b11);
    @(negedge clk);
    check("slow_w_done_first", {o_axi_awvalid, o_axi_wvalid}, 2'b10);
    for (int n = 0; n < 20 && !o_axi_bready; n++) @(negedge clk);
    check("slow_in_b", o_axi_bready, 1);
    check("slow_aw_count", aw_hs - aw0, 1);
    check("slow_w_count", w_hs - w0, 1);
    check("slow_awaddr", cap_awaddr, 32'h40);
    check("slow_wdata", cap_wdata, 32'h1122_3344);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_rready", o_rready, 0);
    check("midrst_wvalid", o_wvalid, 0);
    check("midrst_wdata", o_wdata, 0);
    check("midrst_awaddr", o_axi_awaddr, 0);
    check("midrst_valids", {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_axi_bready, o_axi_rready}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release", {o_rready, o_busy}, 2'b10);
    check("midrst_aw_once", aw_hs - aw0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
